mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 64-bit Avalon-MM SDRAM host port between two requesters.
- Host 0 is the LCD scanout / frame-buffer reader and has high priority. Host 1 is the rasterizer, which does command/vertex reads plus clear and fill writes.
- Adds no bubble on grant switches, tracks outstanding pipelined reads so each readdatavalid beat reaches the requester that issued the read, and guarantees host 1 progress through a starvation limit.

Parameters:
ADDR_WIDTH, 29, word address width (8-byte words)
DATA_WIDTH, 64, data width
MAX_PENDING, 8, max outstanding read commands (power of 2, >=2)
STARVE_LIMIT, 4, consecutive host-0 grants tolerated while host 1 waits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
hN_address  in  ADDR_WIDTH  host N address (N=0,1; same for all hN_ lines)
hN_burstcount  in  8  host N burst length, 0 treated as 1
hN_read  in  1  host N read request
hN_write  in  1  host N write request
hN_writedata  in  DATA_WIDTH  host N write data
hN_byteenable  in  8  host N byte enables
hN_waitrequest  out  1  stall to host N
hN_readdatavalid  out  1  read beat for host N
h_readdata  out  DATA_WIDTH  mem_readdata broadcast to both hosts
mem_address, mem_burstcount, mem_read, mem_write, mem_writedata, mem_byteenable  out  as hN_  to SDRAM
mem_waitrequest  in  1  SDRAM stall
mem_readdata  in  DATA_WIDTH  SDRAM read data
mem_readdatavalid  in  1  SDRAM read beat valid
orphan_count  out  16  saturating count of readdatavalid beats with no pending entry
pending  out  4  current owner-FIFO occupancy

Behaviour:
- Owner register (1 bit) selects the host driven onto mem_*. The selection is combinational, so mem_* follows the owner in the same cycle.
- mem_read = owner.read && !fifo_full.
- mem_write = owner.write.
- A command is accepted when (mem_read || mem_write) && !mem_waitrequest.
- Waitrequest:
  - owner: mem_waitrequest || (read && fifo_full)
  - non-owner: 1
  - during reset: both 1
- Arbitration point: a cycle in which the owner presents no command, or the owner's command (last beat for a write burst) is accepted. The owner update takes effect next cycle, so there is zero bubble.
- Arbitration decision:
  - Host 1 wins if h1 requests and (h0 idle, or starve_cnt == STARVE_LIMIT).
  - Otherwise host 0 wins if it requests.
  - If neither requests, the owner is unchanged (parks).
- starve_cnt: increments on each host-0 grant (accepted host-0 command) while h1 requests; clears when host 1 is granted or h1 is idle; saturates at STARVE_LIMIT.
- Write bursts: burstcount B>1 locks the owner until B beats are accepted. The beat counter loads B-1 on the first beat and decrements per accepted beat. There is no arbitration point until it reaches 0.
- Reads: on acceptance, push {owner, burstcount} into the owner FIFO (depth MAX_PENDING). Reads are single-command, so there is an arbitration point immediately.
- Read return:
  - hN_readdatavalid = mem_readdatavalid && FIFO non-empty && head.owner==N.
  - Head beats decrement per beat; the entry pops on the last beat.
  - A push and a pop in the same cycle keeps occupancy unchanged and is legal when full.
- FIFO full: reads are blocked (host sees waitrequest); writes proceed. Pending reads never block writes.
- Empty FIFO with mem_readdatavalid: no hN_readdatavalid; orphan_count += 1, saturating at 16'hFFFF.
- Simultaneous h0/h1 requests at reset release: host 0 wins.
- Reset state:
  - owner=0, starve_cnt=0, beat counter=0, FIFO empty
  - orphan_count=0, all mem_read/mem_write=0
  - hN_readdatavalid=0, pending=0
- Reset mid-burst or mid-read: all state clears. Late read beats from before the reset count as orphans. The hosts are reset by the same reset.

Decomposition:
- Shared package: ADDR/DATA widths, burstcount width, fifo-entry struct {owner, beats[7:0]}.
- Sub-module read_owner_fifo (synchronous FIFO with head-beat decrement and pop-on-last-beat). The arbiter FSM and mux stay in the top module.

Test Plan:
- Host-0 burst read: h0 read, burstcount 4, mem returns 4 beats after 3 cycles -> h0_readdatavalid for exactly 4 cycles, h1_readdatavalid=0, pending 1->0.
- Contention: both hosts issue back-to-back single writes, mem_waitrequest=0 -> grant sequence 0,0,0,0,1,0,0,0,0,1 (STARVE_LIMIT=4), no idle cycle on mem_write.
- Write-burst lock: h1 write burstcount 8 and h0 read raised at beat 2 -> h0_waitrequest=1 until h1's 8th beat is accepted; h0 read is issued the next cycle.
- FIFO full: 8 outstanding h1 reads with no data returned -> 9th read stalled (mem_read=0); a concurrent h0 write is still accepted; the first returned beat lets the 9th read be issued.
- Interleaved returns: h0 read(2), h1 read(1), h0 read(1) -> beats routed h0,h0,h1,h0.
- Orphans and reset: mem_readdatavalid pulsed with empty FIFO -> orphan_count=1; reset asserted mid 4-beat write burst -> next cycle mem_write=0, owner=0, orphan_count=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the two-host SDRAM port arbiter.
// Holds the owner encoding, the read-owner FIFO entry and the burst-length helper.
package mem_port_arbiter_pkg;

   localparam int ADDR_W  = 29;
   localparam int DATA_W  = 64;
   localparam int BURST_W = 8;
   localparam int BE_W    = 8;

   localparam logic [BURST_W-1:0] ONE_BEAT = 8'd1;

   typedef enum logic {
      OWN_H0 = 1'b0,
      OWN_H1 = 1'b1
   } owner_e;

   typedef struct packed {
      logic               owner;
      logic [BURST_W-1:0] beats;
   } fifo_entry_t;

   // A burstcount of zero means a single beat.
   function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
      return (bc == '0) ? ONE_BEAT : bc;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_read_owner_fifo.sv
// Tracks which host issued each outstanding read and how many beats remain.
// The head entry counts down per returned beat and pops on its last beat.
module read_owner_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   push_owner,
   input  logic [BURST_W-1:0]     push_beats,
   input  logic                   beat,
   output logic                   head_owner,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   fifo_entry_t   slots [DEPTH];
   fifo_entry_t   head;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          head_beat;
   logic          pop;
   logic          do_push;

   assign head       = slots[rd_ptr];
   assign head_owner = head.owner;
   assign empty      = (count == '0);
   assign full       = (count == FULL_COUNT);
   assign head_beat  = beat && !empty;
   assign pop        = head_beat && (head.beats <= ONE_BEAT);
   assign do_push    = push && (!full || pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The push slot and the decremented head slot never coincide: a push
   // into the head slot only happens when full, and then the head pops.
   always_ff @(posedge clock) begin
      if (do_push) slots[wr_ptr] <= '{owner: push_owner, beats: push_beats};
      if (head_beat && !pop) slots[rd_ptr].beats <= head.beats - 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM SDRAM port between the LCD scanout reader (host 0, priority)
// and the rasterizer (host 1), with zero-bubble grant switching and read-return routing.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_W,
   parameter int DATA_WIDTH   = DATA_W,
   parameter int MAX_PENDING  = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] h0_address,
   input  logic [BURST_W-1:0]    h0_burstcount,
   input  logic                  h0_read,
   input  logic                  h0_write,
   input  logic [DATA_WIDTH-1:0] h0_writedata,
   input  logic [BE_W-1:0]       h0_byteenable,
   output logic                  h0_waitrequest,
   output logic                  h0_readdatavalid,
   input  logic [ADDR_WIDTH-1:0] h1_address,
   input  logic [BURST_W-1:0]    h1_burstcount,
   input  logic                  h1_read,
   input  logic                  h1_write,
   input  logic [DATA_WIDTH-1:0] h1_writedata,
   input  logic [BE_W-1:0]       h1_byteenable,
   output logic                  h1_waitrequest,
   output logic                  h1_readdatavalid,
   output logic [DATA_WIDTH-1:0] h_readdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [BURST_W-1:0]    mem_burstcount,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_writedata,
   output logic [BE_W-1:0]       mem_byteenable,
   input  logic                  mem_waitrequest,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   input  logic                  mem_readdatavalid,
   output logic [15:0]           orphan_count,
   output logic [3:0]            pending
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   owner_e                       owner_q, owner_d;
   logic [BURST_W-1:0]           burst_left_q, burst_left_d;
   logic [SW-1:0]                starve_q, starve_d;
   logic [15:0]                  orphan_q;
   logic                         arb_point;

   logic                         sel_h1;
   logic                         sel_read;
   logic                         sel_write;
   logic [BURST_W-1:0]           sel_beats;
   logic                         h0_req;
   logic                         h1_req;
   logic                         accept;
   logic                         h0_grant;

   logic                         fifo_head_owner;
   logic                         fifo_empty;
   logic                         fifo_full;
   logic [$clog2(MAX_PENDING):0] fifo_count;

   assign sel_h1         = (owner_q == OWN_H1);
   assign sel_read       = sel_h1 ? h1_read : h0_read;
   assign sel_write      = sel_h1 ? h1_write : h0_write;
   assign mem_address    = sel_h1 ? h1_address : h0_address;
   assign mem_burstcount = sel_h1 ? h1_burstcount : h0_burstcount;
   assign mem_writedata  = sel_h1 ? h1_writedata : h0_writedata;
   assign mem_byteenable = sel_h1 ? h1_byteenable : h0_byteenable;
   assign sel_beats      = eff_burst(mem_burstcount);

   assign mem_read  = !reset && sel_read && !fifo_full;
   assign mem_write = !reset && sel_write;
   assign accept    = (mem_read || mem_write) && !mem_waitrequest;
   assign h0_grant  = accept && (owner_q == OWN_H0);
   assign h0_req    = h0_read || h0_write;
   assign h1_req    = h1_read || h1_write;

   assign h0_waitrequest = reset || sel_h1 || mem_waitrequest || (h0_read && fifo_full);
   assign h1_waitrequest = reset || !sel_h1 || mem_waitrequest || (h1_read && fifo_full);

   assign h_readdata       = mem_readdata;
   assign h0_readdatavalid = !reset && mem_readdatavalid && !fifo_empty && !fifo_head_owner;
   assign h1_readdatavalid = !reset && mem_readdatavalid && !fifo_empty && fifo_head_owner;
   assign orphan_count     = orphan_q;
   assign pending          = 4'(fifo_count);

   read_owner_fifo #(
      .DEPTH (MAX_PENDING)
   ) u_owner_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (mem_read && accept),
      .push_owner (sel_h1),
      .push_beats (sel_beats),
      .beat       (mem_readdatavalid && !reset),
      .head_owner (fifo_head_owner),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .count      (fifo_count)
   );

   always_comb begin
      owner_d      = owner_q;
      burst_left_d = burst_left_q;
      starve_d     = starve_q;
      arb_point    = 1'b0;

      // The decision sees this cycle's host-0 grant, so host 1 wins right
      // after the STARVE_LIMIT-th consecutive host-0 grant.
      if (!h1_req || owner_q == OWN_H1) begin
         starve_d = '0;
      end else if (h0_grant && starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end

      if (burst_left_q != '0) begin
         if (accept && mem_write) begin
            burst_left_d = burst_left_q - 1'b1;
            arb_point    = (burst_left_q == ONE_BEAT);
         end
      end else if (!mem_read && !mem_write) begin
         arb_point = 1'b1;
      end else if (accept) begin
         if (mem_write && sel_beats != ONE_BEAT) begin
            burst_left_d = sel_beats - 1'b1;
         end else begin
            arb_point = 1'b1;
         end
      end

      if (arb_point) begin
         if (h1_req && (!h0_req || starve_d == STARVE_MAX)) begin
            owner_d = OWN_H1;
         end else if (h0_req) begin
            owner_d = OWN_H0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q      <= OWN_H0;
         burst_left_q <= '0;
         starve_q     <= '0;
         orphan_q     <= '0;
      end else begin
         owner_q      <= owner_d;
         burst_left_q <= burst_left_d;
         starve_q     <= starve_d;
         if (mem_readdatavalid && fifo_empty && orphan_q != 16'hFFFF) begin
            orphan_q <= orphan_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario with inline checks.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [28:0] h0_address, h1_address;
   logic [7:0]  h0_burstcount, h1_burstcount;
   logic        h0_read, h0_write, h1_read, h1_write;
   logic [63:0] h0_writedata, h1_writedata;
   logic [7:0]  h0_byteenable, h1_byteenable;
   logic        h0_waitrequest, h1_waitrequest;
   logic        h0_readdatavalid, h1_readdatavalid;
   logic [63:0] h_readdata;
   logic [28:0] mem_address;
   logic [7:0]  mem_burstcount;
   logic        mem_read, mem_write;
   logic [63:0] mem_writedata;
   logic [7:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [63:0] mem_readdata;
   logic        mem_readdatavalid;
   logic [15:0] orphan_count;
   logic [3:0]  pending;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   mem_port_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .h0_address        (h0_address),
      .h0_burstcount     (h0_burstcount),
      .h0_read           (h0_read),
      .h0_write          (h0_write),
      .h0_writedata      (h0_writedata),
      .h0_byteenable     (h0_byteenable),
      .h0_waitrequest    (h0_waitrequest),
      .h0_readdatavalid  (h0_readdatavalid),
      .h1_address        (h1_address),
      .h1_burstcount     (h1_burstcount),
      .h1_read           (h1_read),
      .h1_write          (h1_write),
      .h1_writedata      (h1_writedata),
      .h1_byteenable     (h1_byteenable),
      .h1_waitrequest    (h1_waitrequest),
      .h1_readdatavalid  (h1_readdatavalid),
      .h_readdata        (h_readdata),
      .mem_address       (mem_address),
      .mem_burstcount    (mem_burstcount),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_byteenable    (mem_byteenable),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .orphan_count      (orphan_count),
      .pending           (pending)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_hosts();
      h0_address = '0; h0_burstcount = 8'd1; h0_read = 0; h0_write = 0;
      h0_writedata = '0; h0_byteenable = 8'hFF;
      h1_address = '0; h1_burstcount = 8'd1; h1_read = 0; h1_write = 0;
      h1_writedata = '0; h1_byteenable = 8'hFF;
      mem_waitrequest = 0; mem_readdata = '0; mem_readdatavalid = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      idle_hosts();
      repeat (2) @(posedge clock);
      #1;
      reset = 0;
   endtask

   task automatic issue_read(input logic host, input logic [7:0] bc, input logic [28:0] addr);
      int w;
      w = 0;
      if (host) begin h1_read = 1; h1_burstcount = bc; h1_address = addr; end
      else begin h0_read = 1; h0_burstcount = bc; h0_address = addr; end
      #1;
      while (((host ? h1_waitrequest : h0_waitrequest) === 1'b1) && w < 10) begin
         tick(); #1; w++;
      end
      n_cmp++;
      if (w >= 10) begin n_fail++; $display("FAIL issue_read_h%0d: stalled %0d cycles, required accept", host, w); end
      tick();
      h0_read = 0; h1_read = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_hosts();
      h0_read = 1; h1_write = 1; mem_readdatavalid = 1;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++; if (h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_h0_wait: got %b want 1", h0_waitrequest); end
      n_cmp++; if (h1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_h1_wait: got %b want 1", h1_waitrequest); end
      n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
      n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
      n_cmp++; if (h0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_h0_rdv: got %b want 0", h0_readdatavalid); end
      // both hosts write at reset release: host 0 must be the owner
      h0_read = 0; h0_write = 1; h0_address = 29'h11; h1_address = 29'h22;
      mem_readdatavalid = 0;
      reset = 0;
      #1;
      n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rel_mem_write: got %b want 1", mem_write); end
      n_cmp++; if (mem_address !== 29'h11) begin n_fail++; $display("FAIL rel_addr: got %h want 11", mem_address); end
      n_cmp++; if (h0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rel_h0_wait: got %b want 0", h0_waitrequest); end
      n_cmp++; if (h1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rel_h1_wait: got %b want 1", h1_waitrequest); end
      n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rel_pending: got %0d want 0", pending); end
      n_cmp++; if (orphan_count !== 16'd0) begin n_fail++; $display("FAIL rel_orphan: got %0d want 0", orphan_count); end
      tick();
      idle_hosts();
   endtask

   task automatic test_burst_read();
      do_reset();
      h0_address = 29'h123; h0_burstcount = 8'd4; h0_read = 1;
      #1;
      n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL brd_mem_read: got %b want 1", mem_read); end
      n_cmp++; if (mem_burstcount !== 8'd4) begin n_fail++; $display("FAIL brd_bc: got %0d want 4", mem_burstcount); end
      n_cmp++; if (mem_address !== 29'h123) begin n_fail++; $display("FAIL brd_addr: got %h want 123", mem_address); end
      tick();
      h0_read = 0;
      #1;
      n_cmp++; if (pending !== 4'd1) begin n_fail++; $display("FAIL brd_pending1: got %0d want 1", pending); end
      tick();
      tick();
      for (int b = 0; b < 4; b++) begin
         mem_readdatavalid = 1; mem_readdata = 64'hD0D0_0000_0000_0000 + 64'(b);
         #1;
         n_cmp++; if (h0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL brd_h0_rdv[%0d]: got %b want 1", b, h0_readdatavalid); end
         n_cmp++; if (h1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL brd_h1_rdv[%0d]: got %b want 0", b, h1_readdatavalid); end
         n_cmp++; if (h_readdata !== 64'hD0D0_0000_0000_0000 + 64'(b)) begin n_fail++; $display("FAIL brd_data[%0d]: got %h", b, h_readdata); end
         tick();
      end
      // a fifth beat has no owner any more
      #1;
      n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("FAIL brd_pending0: got %0d want 0", pending); end
      n_cmp++; if (h0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL brd_extra_rdv: got %b want 0", h0_readdatavalid); end
      tick();
      mem_readdatavalid = 0;
      #1;
      n_cmp++; if (orphan_count !== 16'd1) begin n_fail++; $display("FAIL brd_orphan: got %0d want 1", orphan_count); end
      idle_hosts();
   endtask

   task automatic test_contention();
      int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      logic [36:0] want;
      do_reset();
      h0_address = 29'h100; h0_byteenable = 8'h0F; h0_write = 1;
      h1_address = 29'h200; h1_byteenable = 8'hF0; h1_write = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         want = (exp_seq[i] == 1) ? {29'h200, 8'hF0} : {29'h100, 8'h0F};
         n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL cont_write[%0d]: got %b want 1", i, mem_write); end
         n_cmp++; if ({mem_address, mem_byteenable} !== want) begin n_fail++; $display("FAIL cont_grant[%0d]: got %h want %h", i, {mem_address, mem_byteenable}, want); end
         tick();
      end
      idle_hosts();
   endtask

   task automatic test_write_burst_lock();
      int w;
      do_reset();
      h0_address = 29'h080;
      h1_address = 29'h400; h1_burstcount = 8'd8; h1_write = 1; h1_writedata = 64'h1001;
      w = 0;
      #1;
      while (h1_waitrequest === 1'b1 && w < 8) begin tick(); #1; w++; end
      n_cmp++; if (w >= 8) begin n_fail++; $display("FAIL wbl_grant: stalled %0d cycles, required grant", w); end
      for (int b = 1; b <= 8; b++) begin
         if (b > 1) begin
            h1_writedata = 64'h1000 + 64'(b);
            if (b == 2) h0_read = 1;
            #1;
         end
         n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL wbl_write[%0d]: got %b want 1", b, mem_write); end
         n_cmp++; if (mem_writedata !== 64'h1000 + 64'(b)) begin n_fail++; $display("FAIL wbl_data[%0d]: got %h", b, mem_writedata); end
         if (b >= 2) begin
            n_cmp++; if (h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL wbl_h0_wait[%0d]: got %b want 1", b, h0_waitrequest); end
         end
         tick();
      end
      h1_write = 0;
      #1;
      n_cmp++; if (h0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL wbl_h0_go: got %b want 0", h0_waitrequest); end
      n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL wbl_h0_read: got %b want 1", mem_read); end
      n_cmp++; if (mem_address !== 29'h080) begin n_fail++; $display("FAIL wbl_h0_addr: got %h want 080", mem_address); end
      tick();
      idle_hosts();
   endtask

   task automatic test_fifo_full();
      int issued;
      int w;
      do_reset();
      h1_read = 1;
      issued = 0; w = 0;
      while (issued < 8 && w < 40) begin
         h1_address = 29'h300 + 29'(issued);
         #1;
         if (h1_waitrequest === 1'b0) issued++;
         tick();
         w++;
      end
      n_cmp++; if (issued != 8) begin n_fail++; $display("FAIL ff_issued: got %0d want 8", issued); end
      h1_address = 29'h308;
      #1;
      n_cmp++; if (pending !== 4'd8) begin n_fail++; $display("FAIL ff_pending8: got %0d want 8", pending); end
      n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL ff_blocked: got %b want 0", mem_read); end
      n_cmp++; if (h1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ff_h1_wait: got %b want 1", h1_waitrequest); end
      tick();
      h0_address = 29'h0AA; h0_writedata = 64'h5555; h0_write = 1;
      w = 0;
      #1;
      while (h0_waitrequest === 1'b1 && w < 6) begin tick(); #1; w++; end
      n_cmp++; if (w >= 6) begin n_fail++; $display("FAIL ff_h0_write: stalled %0d cycles, required accept", w); end
      n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL ff_mem_write: got %b want 1", mem_write); end
      n_cmp++; if (mem_address !== 29'h0AA) begin n_fail++; $display("FAIL ff_h0_addr: got %h want 0AA", mem_address); end
      tick();
      h0_write = 0;
      tick();
      tick();
      #1;
      n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL ff_still_blocked: got %b want 0", mem_read); end
      mem_readdatavalid = 1; mem_readdata = 64'hBEEF;
      #1;
      n_cmp++; if (h1_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL ff_h1_rdv: got %b want 1", h1_readdatavalid); end
      n_cmp++; if (h0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL ff_h0_rdv: got %b want 0", h0_readdatavalid); end
      tick();
      mem_readdatavalid = 0;
      #1;
      n_cmp++; if (pending !== 4'd7) begin n_fail++; $display("FAIL ff_pending7: got %0d want 7", pending); end
      n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL ff_ninth: got %b want 1", mem_read); end
      n_cmp++; if (mem_address !== 29'h308) begin n_fail++; $display("FAIL ff_ninth_addr: got %h want 308", mem_address); end
      tick();
      h1_read = 0;
      #1;
      n_cmp++; if (pending !== 4'd8) begin n_fail++; $display("FAIL ff_refill: got %0d want 8", pending); end
      idle_hosts();
   endtask

   task automatic test_interleaved();
      logic exp_owner [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      issue_read(1'b0, 8'd2, 29'h040);
      issue_read(1'b1, 8'd1, 29'h050);
      issue_read(1'b0, 8'd1, 29'h060);
      #1;
      n_cmp++; if (pending !== 4'd3) begin n_fail++; $display("FAIL il_pending3: got %0d want 3", pending); end
      for (int i = 0; i < 4; i++) begin
         mem_readdatavalid = 1; mem_readdata = 64'hA0 + 64'(i);
         #1;
         n_cmp++; if (h0_readdatavalid !== !exp_owner[i]) begin n_fail++; $display("FAIL il_h0_rdv[%0d]: got %b want %b", i, h0_readdatavalid, !exp_owner[i]); end
         n_cmp++; if (h1_readdatavalid !== exp_owner[i]) begin n_fail++; $display("FAIL il_h1_rdv[%0d]: got %b want %b", i, h1_readdatavalid, exp_owner[i]); end
         tick();
      end
      mem_readdatavalid = 0;
      #1;
      n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("FAIL il_pending0: got %0d want 0", pending); end
      n_cmp++; if (orphan_count !== 16'd0) begin n_fail++; $display("FAIL il_orphan: got %0d want 0", orphan_count); end
      idle_hosts();
   endtask

   task automatic test_orphan_reset();
      do_reset();
      mem_readdatavalid = 1;
      #1;
      n_cmp++; if ({h0_readdatavalid, h1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL or_rdv: got %b want 00", {h0_readdatavalid, h1_readdatavalid}); end
      tick();
      mem_readdatavalid = 0;
      #1;
      n_cmp++; if (orphan_count !== 16'd1) begin n_fail++; $display("FAIL or_count1: got %0d want 1", orphan_count); end
      issue_read(1'b0, 8'd1, 29'h010);
      h0_address = 29'h020; h0_burstcount = 8'd4; h0_write = 1;
      #1;
      n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL or_beat1: got %b want 1", mem_write); end
      tick();
      tick();
      reset = 1;
      h0_write = 0;
      #1;
      n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL or_rst_write: got %b want 0", mem_write); end
      tick();
      reset = 0;
      #1;
      n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL or_post_write: got %b want 0", mem_write); end
      n_cmp++; if ({h0_waitrequest, h1_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL or_post_owner: got %b want 01", {h0_waitrequest, h1_waitrequest}); end
      n_cmp++; if (orphan_count !== 16'd0) begin n_fail++; $display("FAIL or_post_orphan: got %0d want 0", orphan_count); end
      n_cmp++; if (pending !== 4'd0) begin n_fail++; $display("FAIL or_post_pending: got %0d want 0", pending); end
      // host 1 must be granted right away: no burst lock survives reset
      h1_address = 29'h0BB; h1_write = 1;
      tick();
      #1;
      n_cmp++; if (h1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL or_h1_wait: got %b want 0", h1_waitrequest); end
      n_cmp++; if (mem_address !== 29'h0BB) begin n_fail++; $display("FAIL or_h1_addr: got %h want 0BB", mem_address); end
      tick();
      h1_write = 0;
      mem_readdatavalid = 1;
      #1;
      n_cmp++; if (h0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL or_late_rdv: got %b want 0", h0_readdatavalid); end
      tick();
      mem_readdatavalid = 0;
      #1;
      n_cmp++; if (orphan_count !== 16'd1) begin n_fail++; $display("FAIL or_late_count: got %0d want 1", orphan_count); end
      idle_hosts();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_burst_read();
      test_contention();
      test_write_burst_lock();
      test_fifo_full();
      test_interleaved();
      test_orphan_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
